// File: rtl/imu_filter.sv
// Six-channel IMU exponential moving-average filter, one channel per cycle through a shared datapath.
// Optional output deadband enabled by defining IMU_FILTER_DEADBAND_EN.
module imu_filter #(
  parameter int SHIFT    = 3,
  parameter int DEADBAND = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [95:0] data_in,
  input  logic        data_valid,
  output logic [95:0] filt_out,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic        primed_q, primed_d;
  logic [95:0] sample_q, sample_d;
  logic [15:0] acc_q [6];
  logic [15:0] acc_d [6];
  logic [95:0] filt_q, filt_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic [15:0]        x_lane   [6];
  logic [15:0]        acc_upd  [6];
  logic [15:0]        lane_out [6];
  logic [95:0]        lanes_packed;
  logic [15:0]        x_cur, y_cur, y_new;
  logic signed [16:0] diff, step;

  if (SHIFT < 1 || SHIFT > 8 || DEADBAND < 0) begin : g_bad_param
    $error("imu_filter: parameter out of range");
  end

  // Shared datapath: the new value always lies between x and y, so dropping the top bit is safe.
  assign x_cur = x_lane[ch_q];
  assign y_cur = acc_q[ch_q];
  assign diff  = $signed({x_cur[15], x_cur}) - $signed({y_cur[15], y_cur});
  assign step  = diff >>> SHIFT;
  assign y_new = primed_q ? 16'({y_cur[15], y_cur} + step) : x_cur;

  for (genvar gi = 0; gi < 6; gi++) begin : g_lane
    assign x_lane[gi]  = sample_q[95-16*gi -: 16];
    assign acc_upd[gi] = (state_q == RUN && ch_q == 3'(gi)) ? y_new : acc_q[gi];
`ifdef IMU_FILTER_DEADBAND_EN
    logic [16:0] mag;
    assign mag = acc_upd[gi][15] ? (17'd0 - {1'b1, acc_upd[gi]}) : {1'b0, acc_upd[gi]};
    assign lane_out[gi] = (mag < 17'(DEADBAND)) ? 16'd0 : acc_upd[gi];
`else
    assign lane_out[gi] = acc_upd[gi];
`endif
    assign lanes_packed[95-16*gi -: 16] = lane_out[gi];
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    primed_d    = primed_q;
    sample_d    = sample_q;
    acc_d       = acc_upd;
    filt_d      = filt_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          sample_d = data_in;
          state_d  = RUN;
          ch_d     = 3'd0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (data_valid) overrun_d = 1'b1;
        if (ch_q == 3'd5) begin
          state_d     = DONE;
          ch_d        = 3'd0;
          filt_d      = lanes_packed;
          out_valid_d = 1'b1;
          primed_d    = 1'b1;
        end else begin
          ch_d = ch_q + 3'd1;
        end
      end
      DONE: begin
        if (data_valid) overrun_d = 1'b1;
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= 3'd0;
      primed_q    <= 1'b0;
      sample_q    <= '0;
      for (int i = 0; i < 6; i++) acc_q[i] <= '0;
      filt_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      primed_q    <= primed_d;
      sample_q    <= sample_d;
      for (int i = 0; i < 6; i++) acc_q[i] <= acc_d[i];
      filt_q      <= filt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign filt_out  = filt_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_imu_filter.sv
// Scoreboard bench for imu_filter: stimulus pushes hand-computed results, a monitor checks each out_valid.
// Expected lanes are passed through the deadband when IMU_FILTER_DEADBAND_EN is defined.
module tb_imu_filter;

  logic        clk;
  logic        reset;
  logic [95:0] data_in;
  logic        data_valid;
  logic [95:0] filt_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [95:0] data;
  } exp_t;
  exp_t exp_q[$];

  imu_filter #(.SHIFT(3), .DEADBAND(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .filt_out   (filt_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] rep(input logic [15:0] v);
    return {6{v}};
  endfunction

  function automatic logic [95:0] dbw(input logic [95:0] w);
    logic [95:0] r;
    r = w;
`ifdef IMU_FILTER_DEADBAND_EN
    for (int i = 0; i < 6; i++) begin
      int v;
      v = $signed(w[95-16*i -: 16]);
      if (v > -64 && v < 64) r[95-16*i -: 16] = 16'd0;
    end
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: every out_valid must match the oldest expected result, in the right cycle.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_valid_unexpected cycle=%0d got=1 want=0", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_cycle", 96'(cyc), 96'(e.cyc));
        chk("filt_out", filt_out, e.data);
        $display("txn cycle=%0d filt_out=%h", cyc, filt_out);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic send(input logic [95:0] w, input logic [95:0] e);
    int t;
    @(posedge clk); #1;
    data_in    = w;
    data_valid = 1'b1;
    t          = cyc;
    exp_q.push_back('{t + 7, dbw(e)});
    @(negedge clk); chk("busy_at_t", 96'(busy), 96'(0));
    @(posedge clk); #1 data_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); chk("busy_run", 96'(busy), 96'(1));
    end
    @(negedge clk); chk("busy_after", 96'(busy), 96'(0));
  endtask

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_filt_out", filt_out, 96'd0);
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_overrun", 96'(overrun), 96'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Prime, decay toward zero, then per-lane distinct steps to pin channel packing.
    send(rep(16'h0100), rep(16'h0100));
    send(rep(16'h0000), rep(16'h00E0));
    send({16'd224, 16'd304, 16'd384, 16'd464, 16'd544, 16'd624},
         {16'h00E0, 16'h00EA, 16'h00F4, 16'h00FE, 16'h0108, 16'h0112});

    do_reset();
    send(rep(16'hFCE0), rep(16'hFCE0));
    send(rep(16'h0000), rep(16'hFD44));

    do_reset();
    send(rep(16'h0000), rep(16'h0000));
    send(rep(16'hFFFF), rep(16'hFFFF));

    do_reset();
    send(rep(16'h8000), rep(16'h8000));
    send(rep(16'h7FFF), rep(16'h9FFF));

    // Overrun: second strobe at t+3 is dropped, result comes from the first sample only.
    begin
      int t;
      @(posedge clk); #1;
      data_in    = rep(16'h7FFF);
      data_valid = 1'b1;
      t          = cyc;
      exp_q.push_back('{t + 7, dbw(rep(16'hBBFF))});
      @(posedge clk); #1 data_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      data_in    = rep(16'h0000);
      data_valid = 1'b1;
      @(posedge clk); #1 data_valid = 1'b0;
      @(negedge clk);
      chk("overrun_set", 96'(overrun), 96'(1));
      chk("busy_during_overrun", 96'(busy), 96'(1));
      repeat (6) @(negedge clk);
      chk("overrun_sticky", 96'(overrun), 96'(1));
      chk("busy_idle_after_overrun", 96'(busy), 96'(0));
    end

    // Reset at t+4 aborts the computation; the next sample re-primes.
    begin
      @(posedge clk); #1;
      data_in    = rep(16'h0300);
      data_valid = 1'b1;
      @(posedge clk); #1 data_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_filt_out", filt_out, 96'd0);
      chk("abort_busy", 96'(busy), 96'(0));
      chk("abort_overrun", 96'(overrun), 96'(0));
      repeat (6) @(negedge clk);
      chk("abort_filt_hold", filt_out, 96'd0);
    end
    send(rep(16'h0200), rep(16'h0200));

    // Reset wins over data_valid in the same cycle.
    begin
      @(posedge clk); #1;
      reset      = 1'b1;
      data_valid = 1'b1;
      data_in    = rep(16'h1234);
      @(posedge clk); #1;
      reset      = 1'b0;
      data_valid = 1'b0;
      @(negedge clk);
      chk("prio_busy", 96'(busy), 96'(0));
      repeat (8) @(negedge clk);
      chk("prio_filt_out", filt_out, 96'd0);
    end
    send(rep(16'h0040), rep(16'h0040));

    // Small values around the deadband threshold on lane 0.
    do_reset();
    send({16'd50, 80'd0}, {16'd50, 80'd0});
    send({16'd200, 80'd0}, {16'd68, 80'd0});

    repeat (4) @(negedge clk);
    chk("pending_results", 96'(exp_q.size()), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imu_filter.md
IMU_FILTER -- requirements
Module: imu_filter

Interface
REQ-001 SHALL have parameter SHIFT, default 3, EMA smoothing factor alpha = 2^-SHIFT, legal range 1..8.
REQ-002 SHALL have parameter DEADBAND, default 64, magnitude below which a reported output reads zero; used only when IMU_FILTER_DEADBAND_EN is defined.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  96  six signed 16-bit samples; channel i = data_in[95-16i -: 16], i = 0..5.
REQ-006 SHALL have port data_valid  input  1  one-cycle strobe marking a new data_in word.
REQ-007 SHALL have port filt_out  output  96  six signed 16-bit filtered values, same channel packing as data_in.
REQ-008 SHALL have port out_valid  output  1  one-cycle pulse when filt_out updates.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port overrun  output  1  sticky flag: a data_valid strobe was dropped.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on data_valid; RUN->DONE after channel 5; DONE->IDLE unconditionally.
REQ-012 SHALL latch data_in into an internal 96-bit register on the IDLE cycle where data_valid=1; data_in is ignored at all other times.
REQ-013 SHALL process one channel per RUN cycle, in order 0..5, using a 3-bit channel counter and one shared subtract/shift/add datapath.
REQ-014 SHALL compute per channel y_new = y + ((x - y) >>> SHIFT): 17-bit signed difference, arithmetic (floor) shift, 16-bit result; y_new never overflows because it lies between x and y.
REQ-015 SHALL, when not primed, load y = x for every channel (no filtering), then set primed=1 at the end of that sample.
REQ-016 SHALL update all six filt_out lanes together, and pulse out_valid, during DONE; filt_out holds its value at all other times.
REQ-017 SHALL have latency 7: data_valid at cycle t -> RUN for t+1..t+6 -> out_valid=1 at t+7; minimum accepted strobe spacing is 8 cycles.
REQ-018 SHALL drop data_valid asserted during RUN or DONE, set overrun=1, and leave the in-flight computation unaffected.
REQ-019 SHALL clear overrun only by reset.

Reset
REQ-020 SHALL, while reset=1, force state=IDLE, channel counter=0, primed=0, all accumulators=0, filt_out=0, out_valid=0, busy=0, overrun=0.
REQ-021 SHALL abort an in-flight computation on reset asserted mid-RUN without producing out_valid; the next accepted sample after reset re-primes.
REQ-022 SHALL take reset priority over data_valid in the same cycle.

Configuration
REQ-023 SHALL, with IMU_FILTER_DEADBAND_EN defined, report filt_out lane = 0 when |y| < DEADBAND, with the internal accumulator unaffected; without the macro, filt_out = y exactly and no deadband logic is present.

Verification
REQ-024 SHALL cover: after reset, data_valid with all lanes 0x0100 at t -> busy=1 for t+1..t+7, out_valid=1 at t+7 only, every lane 0x0100 (prime).
REQ-025 SHALL cover: then all lanes 0x0000 -> every lane 0x00E0; separately prime at -800 then input 0 -> -700 (0xFD44).
REQ-026 SHALL cover: prime 0 then input -1 -> -1 (floor shift); prime -32768 then input 32767 -> -24577 with no wrap.
REQ-027 SHALL cover: second data_valid at t+3 -> ignored, overrun=1 and stays 1, out_valid still at t+7 with values from the first sample only.
REQ-028 SHALL cover: reset asserted at t+4 -> no out_valid, all outputs 0; next sample 0x0200 primes to 0x0200.
REQ-029 SHALL cover, with IMU_FILTER_DEADBAND_EN and DEADBAND=64: prime lane 0 at 50 -> filt_out lane 0 reads 0; then input 200 -> internal 68, lane 0 reads 68.
